// File: rtl/seg7_display_ctrl.sv
// Writes the six hex digits of a value, or six blanks, into the seg7 HEX register bank.
// The processor shares the bank's single write port and always wins it.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for Start/Clear; the bank port is free for the processor
// WRITE | issuing one digit write per free cycle, digit 0 first
module seg7_display_ctrl #(
    parameter int DIGITS   = 6,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic                  i_start,
    input  logic                  i_clear,
    input  logic [6:0]            i_cpu_data,
    input  logic [2:0]            i_cpu_addr,
    input  logic                  i_cpu_wr,
    output logic [6:0]            o_data,
    output logic [2:0]            o_addr,
    output logic                  o_sel,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic {IDLE, WRITE} state_t;
    typedef enum logic {MODE_SHOW, MODE_BLANK} mode_t;

    localparam logic [2:0] LAST = 3'(DIGITS - 1);

    state_t               r_state, w_state_nx;
    mode_t                r_mode, w_mode_nx;
    logic [2:0]           r_count, w_count_nx;
    logic [4*DIGITS-1:0]  r_shadow, w_shadow_nx;
    logic [6:0]           r_data, w_data_nx;
    logic [2:0]           r_addr, w_addr_nx;
    logic                 r_sel, w_sel_nx;
    logic                 r_busy, w_busy_nx;
    logic                 r_done, w_done_nx;

    logic [4*DIGITS-1:0]  w_upper;
    logic [6:0]           w_pattern;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0: hex_decode = 7'h3F;
            4'h1: hex_decode = 7'h06;
            4'h2: hex_decode = 7'h5B;
            4'h3: hex_decode = 7'h4F;
            4'h4: hex_decode = 7'h66;
            4'h5: hex_decode = 7'h6D;
            4'h6: hex_decode = 7'h7D;
            4'h7: hex_decode = 7'h07;
            4'h8: hex_decode = 7'h7F;
            4'h9: hex_decode = 7'h6F;
            4'hA: hex_decode = 7'h77;
            4'hB: hex_decode = 7'h7C;
            4'hC: hex_decode = 7'h39;
            4'hD: hex_decode = 7'h5E;
            4'hE: hex_decode = 7'h79;
            4'hF: hex_decode = 7'h71;
        endcase
    endfunction

    // Everything from the current digit upward; zero means this digit is a leading zero.
    assign w_upper = r_shadow >> {r_count, 2'b00};

    always_comb begin
        w_pattern = hex_decode(w_upper[3:0]);
        if (r_mode == MODE_BLANK) begin
            w_pattern = 7'h00;
        end else if (BLANK_LZ && (r_count != 3'd0) && (w_upper == '0)) begin
            w_pattern = 7'h00;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_mode_nx   = r_mode;
        w_count_nx  = r_count;
        w_shadow_nx = r_shadow;
        w_data_nx   = r_data;
        w_addr_nx   = r_addr;
        w_sel_nx    = 1'b0;
        w_done_nx   = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_clear) begin
                    w_mode_nx  = MODE_BLANK;
                    w_count_nx = 3'd0;
                    w_state_nx = WRITE;
                end else if (i_start) begin
                    w_shadow_nx = i_value;
                    w_mode_nx   = MODE_SHOW;
                    w_count_nx  = 3'd0;
                    w_state_nx  = WRITE;
                end
            end
            WRITE: begin
                if (!i_cpu_wr) begin
                    w_sel_nx  = 1'b1;
                    w_addr_nx = r_count;
                    w_data_nx = w_pattern;
                    if (r_count == LAST) begin
                        w_done_nx  = 1'b1;
                        w_count_nx = 3'd0;
                        w_state_nx = IDLE;
                        // A request arriving with the final write chains straight into
                        // the next sequence so back-to-back displays have no gap.
                        if (i_clear) begin
                            w_mode_nx  = MODE_BLANK;
                            w_state_nx = WRITE;
                        end else if (i_start) begin
                            w_shadow_nx = i_value;
                            w_mode_nx   = MODE_SHOW;
                            w_state_nx  = WRITE;
                        end
                    end else begin
                        w_count_nx = 3'(r_count + 3'd1);
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase

        if (i_cpu_wr) begin
            w_sel_nx  = 1'b1;
            w_addr_nx = i_cpu_addr;
            w_data_nx = i_cpu_data;
        end

        w_busy_nx = (w_state_nx == WRITE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_mode   <= MODE_SHOW;
            r_count  <= 3'd0;
            r_shadow <= '0;
            r_data   <= 7'h00;
            r_addr   <= 3'd0;
            r_sel    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_mode   <= w_mode_nx;
            r_count  <= w_count_nx;
            r_shadow <= w_shadow_nx;
            r_data   <= w_data_nx;
            r_addr   <= w_addr_nx;
            r_sel    <= w_sel_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
        end
    end

    assign o_data = r_data;
    assign o_addr = r_addr;
    assign o_sel  = r_sel;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench for seg7_display_ctrl: expected bank writes are queued when stimulus
// is driven and popped as the controller presents each write.
module tb_seg7_display_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] value;
    logic        start, clear;
    logic [6:0]  cpu_data;
    logic [2:0]  cpu_addr;
    logic        cpu_wr;
    logic [6:0]  o_data;
    logic [2:0]  o_addr;
    logic        o_sel, o_busy, o_done;

    seg7_display_ctrl #(.DIGITS(6), .BLANK_LZ(1'b1)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_value    (value),
        .i_start    (start),
        .i_clear    (clear),
        .i_cpu_data (cpu_data),
        .i_cpu_addr (cpu_addr),
        .i_cpu_wr   (cpu_wr),
        .o_data     (o_data),
        .o_addr     (o_addr),
        .o_sel      (o_sel),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [10:0] exp_q [$];
    int vectors = 0;
    int errors  = 0;
    int cyc = 0, busy_cnt = 0, done_cyc = 0, run = 0, max_run = 0, s0 = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected (addr, data, done) for one sequence; an optional processor write
    // (3, 7F) is slotted in ahead of digit cpu_slot.
    task automatic push_seq(input logic [23:0] v, input bit blank, input int cpu_slot);
        logic [23:0] sh;
        logic [6:0]  d;
        for (int i = 0; i < 6; i++) begin
            if (i == cpu_slot) exp_q.push_back({3'd3, 7'h7F, 1'b0});
            sh = v >> (4 * i);
            if (blank || (i > 0 && sh == 24'h0)) d = 7'h00;
            else d = SEG[sh[3:0]];
            exp_q.push_back({3'(i), d, (i == 5)});
        end
    endtask

    // One clock: inputs set before the call are sampled at the rising edge,
    // outputs are checked on the following falling edge.
    task automatic step();
        logic [10:0] e;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (o_busy) busy_cnt++;
        if (o_done) done_cyc = cyc;
        if (o_sel) begin
            run++;
            if (run > max_run) max_run = run;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(o_sel), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr_data_done", 32'({o_addr, o_data, o_done}), 32'(e));
            end
        end else begin
            run = 0;
            chk("done_without_sel", 32'(o_done), 32'd0);
        end
    endtask

    task automatic begin_scenario();
        busy_cnt = 0; done_cyc = 0; max_run = 0; s0 = cyc;
    endtask

    task automatic run_show(input logic [23:0] v, input string tag);
        begin_scenario();
        value = v; start = 1'b1;
        push_seq(v, 1'b0, -1);
        step();
        start = 1'b0;
        value = ~v;
        repeat (8) step();
        chk({tag, "_done_latency"}, 32'(done_cyc - s0), 32'd7);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd6);
        chk({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; value = '0; start = 1'b0; clear = 1'b0;
        cpu_data = '0; cpu_addr = '0; cpu_wr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_sel", 32'(o_sel), 32'd0);
            chk("idle_busy", 32'(o_busy), 32'd0);
            chk("idle_done", 32'(o_done), 32'd0);
            chk("idle_data", 32'(o_data), 32'd0);
        end

        run_show(24'h12AB3F, "hex_12AB3F");
        run_show(24'h000042, "lz_000042");
        run_show(24'h000000, "lz_zero");

        // Processor write on the second sequence cycle steals one slot.
        begin_scenario();
        value = 24'h12AB3F; start = 1'b1;
        push_seq(24'h12AB3F, 1'b0, 1);
        step();
        start = 1'b0;
        step();
        cpu_wr = 1'b1; cpu_addr = 3'd3; cpu_data = 7'h7F;
        step();
        cpu_wr = 1'b0;
        repeat (8) step();
        chk("cpu_done_latency", 32'(done_cyc - s0), 32'd8);
        chk("cpu_busy_cycles", 32'(busy_cnt), 32'd7);
        chk("cpu_queue_drained", 32'(exp_q.size()), 32'd0);

        // Out-of-range processor address passes straight through while idle.
        cpu_wr = 1'b1; cpu_addr = 3'd7; cpu_data = 7'h55;
        exp_q.push_back({3'd7, 7'h55, 1'b0});
        step();
        cpu_wr = 1'b0;
        step();
        chk("cpu_idle_queue_drained", 32'(exp_q.size()), 32'd0);

        // Clear beats Start; a Start while busy is ignored.
        begin_scenario();
        value = 24'hFFFFFF; start = 1'b1; clear = 1'b1;
        push_seq(24'hFFFFFF, 1'b1, -1);
        step();
        start = 1'b0; clear = 1'b0;
        step(); step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        chk("clear_done_latency", 32'(done_cyc - s0), 32'd7);
        chk("clear_busy_cycles", 32'(busy_cnt), 32'd6);
        chk("clear_queue_drained", 32'(exp_q.size()), 32'd0);

        // Start alongside the final write chains a second sequence with no gap.
        begin_scenario();
        value = 24'h12AB3F; start = 1'b1;
        push_seq(24'h12AB3F, 1'b0, -1);
        step();
        start = 1'b0;
        repeat (5) step();
        value = 24'h000042; start = 1'b1;
        push_seq(24'h000042, 1'b0, -1);
        step();
        start = 1'b0;
        repeat (8) step();
        chk("chain_sel_run", 32'(max_run), 32'd12);
        chk("chain_busy_cycles", 32'(busy_cnt), 32'd12);
        chk("chain_queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-sequence abandons the remaining writes.
        begin_scenario();
        value = 24'h654321; start = 1'b1;
        push_seq(24'h654321, 1'b0, -1);
        step();
        start = 1'b0;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sel", 32'(o_sel), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        exp_q.delete();
        step(); step();
        rst_n = 1'b1;
        busy_cnt = 0;
        repeat (10) step();
        chk("post_rst_busy_cycles", 32'(busy_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
